// File: rtl/ocl_multi_cmd_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ocl_multi_cmd_bridge_if
// Description : AXI-Lite 32b slave bus plus node-engine command/response
//               streams for the multi-channel OCL command bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface ocl_multi_cmd_bridge_if #(
   parameter int NUM_CH = 4
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // AXI-Lite write address / data / response
   logic              awvalid;
   logic              awready;
   logic [31:0]       awaddr;
   logic              wvalid;
   logic              wready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              bvalid;
   logic [1:0]        bresp;
   logic              bready;

   // AXI-Lite read address / data
   logic              arvalid;
   logic              arready;
   logic [31:0]       araddr;
   logic              rvalid;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rready;

   // Command stream towards the node engine
   logic              cmd_valid;
   logic              cmd_ready;
   logic [CH_W-1:0]   cmd_ch;
   logic [2:0]        cmd_op;
   logic              cmd_mo;
   logic [27:0]       cmd_id;

   // Response stream from the node engine
   logic              rsp_valid;
   logic              rsp_ready;
   logic [2:0]        rsp_op;
   logic              rsp_mo;
   logic [27:0]       rsp_id;

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, rready,
      input  cmd_ready,
      input  rsp_valid, rsp_op, rsp_mo, rsp_id,
      output awready, wready, bvalid, bresp,
      output arready, rvalid, rdata, rresp,
      output cmd_valid, cmd_ch, cmd_op, cmd_mo, cmd_id,
      output rsp_ready
   );

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, rready,
      output cmd_ready,
      output rsp_valid, rsp_op, rsp_mo, rsp_id,
      input  awready, wready, bvalid, bresp,
      input  arready, rvalid, rdata, rresp,
      input  cmd_valid, cmd_ch, cmd_op, cmd_mo, cmd_id,
      input  rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/ocl_multi_cmd_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ocl_multi_cmd_bridge
// Description : AXI-Lite slave that turns host writes into per-channel
//               commands (command FIFO) and returns node results to host
//               reads (response FIFO), with error responses and drop status.
// Revision    : 1.0 - initial release
// ============================================================================
module ocl_multi_cmd_bridge #(
   parameter int          NUM_CH    = 4,
   parameter int          CMD_DEPTH = 16,
   parameter int          RSP_DEPTH = 16,
   parameter logic [31:0] CMD_BASE  = 32'h500,
   parameter logic [31:0] RSP_ADDR  = 32'h600,
   parameter logic [31:0] STAT_ADDR = 32'h604
) (
   input  logic                   clk,
   input  logic                   rst,
   ocl_multi_cmd_bridge_if.slave  bus
);
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CMD_AW  = $clog2(CMD_DEPTH);
   localparam int CMD_CW  = CMD_AW + 1;
   localparam int RSP_AW  = $clog2(RSP_DEPTH);
   localparam int RSP_CW  = RSP_AW + 1;
   localparam int CMD_EW  = CH_W + 32;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [31:0] RSP_EMPTY_MARK = 32'hE000_0000;
   localparam logic [31:0] CMD_SPAN = 32'(4 * NUM_CH);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;

   // ---------------------------------------------------------------- state
   wr_state_t          r_wr_state;
   logic               r_awready;
   logic               r_wready;
   logic               r_bvalid;
   logic [1:0]         r_bresp;
   logic [31:0]        r_wr_addr;
   logic [7:0]         r_drop_cnt;

   rd_state_t          r_rd_state;
   logic               r_arready;
   logic               r_rvalid;
   logic [31:0]        r_rdata;
   logic [1:0]         r_rresp;

   logic [CMD_EW-1:0]  r_cmd_mem [CMD_DEPTH];
   logic [CMD_AW-1:0]  r_cmd_wp;
   logic [CMD_AW-1:0]  r_cmd_rp;
   logic [CMD_CW-1:0]  r_cmd_cnt;

   logic [31:0]        r_rsp_mem [RSP_DEPTH];
   logic [RSP_AW-1:0]  r_rsp_wp;
   logic [RSP_AW-1:0]  r_rsp_rp;
   logic [RSP_CW-1:0]  r_rsp_cnt;

   // ---------------------------------------------------------------- decode
   logic [31:0]        w_wr_off;
   logic               w_wr_is_cmd;
   logic [CH_W-1:0]    w_wr_ch;
   logic [2:0]         w_wr_op;
   logic               w_wr_fire;
   logic               w_wr_drop;
   logic               w_wr_clr;
   logic [1:0]         w_wr_resp;
   logic               w_cmd_full;
   logic               w_cmd_push;
   logic               w_cmd_pop;

   logic [31:0]        w_rd_off;
   logic               w_rd_is_cmd;
   logic               w_ar_fire;
   logic [31:0]        w_rd_data;
   logic [1:0]         w_rd_resp;
   logic               w_rsp_full;
   logic               w_rsp_empty;
   logic               w_rsp_push;
   logic               w_rsp_pop;
   logic [31:0]        w_stat;

   assign w_cmd_full  = (r_cmd_cnt == CMD_CW'(CMD_DEPTH));
   assign w_rsp_full  = (r_rsp_cnt == RSP_CW'(RSP_DEPTH));
   assign w_rsp_empty = (r_rsp_cnt == '0);

   assign w_wr_off    = r_wr_addr - CMD_BASE;
   assign w_wr_is_cmd = (w_wr_off < CMD_SPAN) && (w_wr_off[1:0] == 2'b00);
   assign w_wr_ch     = CH_W'(w_wr_off >> 2);
   assign w_wr_op     = (bus.wdata[31:29] <= 3'd3) ? bus.wdata[31:29] : 3'd4;
   assign w_wr_fire   = r_wready && bus.wvalid;

   // Write decode: classify the beat at the W handshake (full sampled pre-pop)
   always_comb begin
      w_wr_drop  = 1'b0;
      w_wr_clr   = 1'b0;
      w_cmd_push = 1'b0;
      w_wr_resp  = RESP_DECERR;
      if (w_wr_is_cmd) begin
         if ((bus.wstrb != 4'hF) || w_cmd_full) begin
            w_wr_drop = w_wr_fire;
            w_wr_resp = RESP_SLVERR;
         end else begin
            w_cmd_push = w_wr_fire;
            w_wr_resp  = RESP_OKAY;
         end
      end else if (r_wr_addr == STAT_ADDR) begin
         w_wr_clr  = w_wr_fire;
         w_wr_resp = RESP_OKAY;
      end
   end

   assign w_cmd_pop   = (r_cmd_cnt != '0) && bus.cmd_ready;

   assign w_rd_off    = bus.araddr - CMD_BASE;
   assign w_rd_is_cmd = (w_rd_off < CMD_SPAN) && (w_rd_off[1:0] == 2'b00);
   assign w_ar_fire   = r_arready && bus.arvalid;
   assign w_stat      = {r_drop_cnt, 8'(r_rsp_cnt), 8'(r_cmd_cnt), 6'b0, w_rsp_empty, w_cmd_full};

   // Read decode: data captured at the AR handshake; no rsp bypass
   always_comb begin
      w_rsp_pop = 1'b0;
      w_rd_data = 32'h0;
      w_rd_resp = RESP_OKAY;
      if (bus.araddr == RSP_ADDR) begin
         if (!w_rsp_empty) begin
            w_rd_data = r_rsp_mem[r_rsp_rp];
            w_rsp_pop = w_ar_fire;
         end else begin
            w_rd_data = RSP_EMPTY_MARK;
         end
      end else if (bus.araddr == STAT_ADDR) begin
         w_rd_data = w_stat;
      end else if (!w_rd_is_cmd) begin
         w_rd_resp = RESP_DECERR;
      end
   end

   assign w_rsp_push = bus.rsp_valid && !w_rsp_full;

   // Write channel FSM with registered handshake outputs and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_state <= W_IDLE;
         r_awready  <= 1'b1;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_addr  <= 32'h0;
         r_drop_cnt <= 8'h0;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               if (bus.awvalid) begin
                  r_wr_addr  <= bus.awaddr;
                  r_awready  <= 1'b0;
                  r_wready   <= 1'b1;
                  r_wr_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (bus.wvalid) begin
                  r_wready   <= 1'b0;
                  r_bvalid   <= 1'b1;
                  r_bresp    <= w_wr_resp;
                  r_wr_state <= W_RESP;
                  if (w_wr_clr) begin
                     r_drop_cnt <= 8'h0;
                  end else if (w_wr_drop && (r_drop_cnt != 8'hFF)) begin
                     r_drop_cnt <= r_drop_cnt + 8'h1;
                  end
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  r_bvalid   <= 1'b0;
                  r_bresp    <= RESP_OKAY;
                  r_awready  <= 1'b1;
                  r_wr_state <= W_IDLE;
               end
            end
            default: begin
               r_wr_state <= W_IDLE;
               r_awready  <= 1'b1;
               r_wready   <= 1'b0;
               r_bvalid   <= 1'b0;
            end
         endcase
      end
   end

   // Read channel FSM: one outstanding read, data held until rready
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_state <= R_IDLE;
         r_arready  <= 1'b1;
         r_rvalid   <= 1'b0;
         r_rdata    <= 32'h0;
         r_rresp    <= RESP_OKAY;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (bus.arvalid) begin
                  r_arready  <= 1'b0;
                  r_rvalid   <= 1'b1;
                  r_rdata    <= w_rd_data;
                  r_rresp    <= w_rd_resp;
                  r_rd_state <= R_RESP;
               end
            end
            R_RESP: begin
               if (bus.rready) begin
                  r_arready  <= 1'b1;
                  r_rvalid   <= 1'b0;
                  r_rdata    <= 32'h0;
                  r_rresp    <= RESP_OKAY;
                  r_rd_state <= R_IDLE;
               end
            end
            default: begin
               r_rd_state <= R_IDLE;
               r_arready  <= 1'b1;
               r_rvalid   <= 1'b0;
            end
         endcase
      end
   end

   // Command FIFO storage (no reset needed: guarded by the count)
   always_ff @(posedge clk) begin
      if (w_cmd_push) begin
         r_cmd_mem[r_cmd_wp] <= {w_wr_ch, w_wr_op, bus.wdata[28], bus.wdata[27:0]};
      end
   end

   // Command FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_cmd_cnt <= '0;
      end else begin
         if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
         if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + 1'b1;
         case ({w_cmd_push, w_cmd_pop})
            2'b10:   r_cmd_cnt <= r_cmd_cnt + 1'b1;
            2'b01:   r_cmd_cnt <= r_cmd_cnt - 1'b1;
            default: r_cmd_cnt <= r_cmd_cnt;
         endcase
      end
   end

   // Response FIFO storage
   always_ff @(posedge clk) begin
      if (w_rsp_push) begin
         r_rsp_mem[r_rsp_wp] <= {bus.rsp_op, bus.rsp_mo, bus.rsp_id};
      end
   end

   // Response FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_wp  <= '0;
         r_rsp_rp  <= '0;
         r_rsp_cnt <= '0;
      end else begin
         if (w_rsp_push) r_rsp_wp <= r_rsp_wp + 1'b1;
         if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + 1'b1;
         case ({w_rsp_push, w_rsp_pop})
            2'b10:   r_rsp_cnt <= r_rsp_cnt + 1'b1;
            2'b01:   r_rsp_cnt <= r_rsp_cnt - 1'b1;
            default: r_rsp_cnt <= r_rsp_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.awready   = r_awready;
   assign bus.wready    = r_wready;
   assign bus.bvalid    = r_bvalid;
   assign bus.bresp     = r_bresp;
   assign bus.arready   = r_arready;
   assign bus.rvalid    = r_rvalid;
   assign bus.rdata     = r_rdata;
   assign bus.rresp     = r_rresp;
   assign bus.cmd_valid = (r_cmd_cnt != '0);
   assign {bus.cmd_ch, bus.cmd_op, bus.cmd_mo, bus.cmd_id} = r_cmd_mem[r_cmd_rp];
   assign bus.rsp_ready = !w_rsp_full;

endmodule
`default_nettype wire

// File: tb/tb_ocl_multi_cmd_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ocl_multi_cmd_bridge
// Description : Self-checking bench for ocl_multi_cmd_bridge: queue-based
//               reference model compared every cycle, directed scenarios
//               with literal expectations, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ocl_multi_cmd_bridge;
   localparam int          NUM_CH    = 4;
   localparam int          CH_W      = 2;
   localparam int          CMD_DEPTH = 16;
   localparam int          RSP_DEPTH = 16;
   localparam logic [31:0] CMD_BASE  = 32'h500;
   localparam logic [31:0] RSP_ADDR  = 32'h600;
   localparam logic [31:0] STAT_ADDR = 32'h604;
   localparam int          LIM       = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ocl_multi_cmd_bridge_if #(.NUM_CH(NUM_CH)) bus ();

   ocl_multi_cmd_bridge #(
      .NUM_CH(NUM_CH), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH),
      .CMD_BASE(CMD_BASE), .RSP_ADDR(RSP_ADDR), .STAT_ADDR(STAT_ADDR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [CH_W+31:0] cmd_q[$];
   logic [31:0]      rsp_q[$];
   logic [7:0]       drop_m;
   bit               model_ok = 0;
   bit               aw_got, b_pend, r_pend;
   logic [31:0]      w_addr;
   logic [1:0]       exp_bresp, exp_rresp;
   logic [31:0]      exp_rdata;
   logic [CH_W+31:0] last_cmd;
   int               pops = 0;

   // driver controls
   int               cr_mode = 0;   // 0 hold low, 1 always ready, 2 random
   int               rv_mode = 0;   // 0 idle, 2 random responses
   logic [31:0]      dir_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tmo(input string name);
      total++;
      bad++;
      $display("FAIL timeout %s at %0t", name, $time);
   endtask

   function automatic bit is_cmd(input logic [31:0] a);
      return (a >= CMD_BASE) && (a < CMD_BASE + 32'(4 * NUM_CH)) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [2:0] op_map(input logic [2:0] op);
      return (op <= 3'd3) ? op : 3'd4;
   endfunction

   // Check outputs against the model, then advance the model by the coming edge
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("awready", bus.awready, !aw_got && !b_pend);
            chk("wready", bus.wready, aw_got);
            chk("bvalid", bus.bvalid, b_pend);
            if (b_pend) chk("bresp", bus.bresp, exp_bresp);
            chk("arready", bus.arready, !r_pend);
            chk("rvalid", bus.rvalid, r_pend);
            chk("rdata", bus.rdata, r_pend ? exp_rdata : 32'h0);
            if (r_pend) chk("rresp", bus.rresp, exp_rresp);
            chk("cmd_valid", bus.cmd_valid, cmd_q.size() != 0);
            if (cmd_q.size() != 0)
               chk("cmd_payload", {bus.cmd_ch, bus.cmd_op, bus.cmd_mo, bus.cmd_id}, cmd_q[0]);
            chk("rsp_ready", bus.rsp_ready, rsp_q.size() < RSP_DEPTH);
         end
         if (rst) begin
            cmd_q.delete();
            rsp_q.delete();
            drop_m = 8'h0;
            aw_got = 0; b_pend = 0; r_pend = 0;
            model_ok = 1;
         end else if (model_ok) begin
            int  csz = cmd_q.size();
            int  rsz = rsp_q.size();
            bit  cmd_pop  = (csz != 0) && bus.cmd_ready;
            bit  rsp_push = bus.rsp_valid && (rsz < RSP_DEPTH);
            bit  ar_fire  = bus.arvalid && !r_pend;
            bit  r_fire   = r_pend && bus.rready;
            bit  aw_fire  = bus.awvalid && !aw_got && !b_pend;
            bit  w_fire   = bus.wvalid && aw_got;
            bit  b_fire   = b_pend && bus.bready;
            bit  rsp_pop  = 0;
            bit  cmd_push = 0;
            logic [CH_W+31:0] new_cmd = '0;
            if (cmd_pop) begin
               last_cmd = {bus.cmd_ch, bus.cmd_op, bus.cmd_mo, bus.cmd_id};
               pops++;
            end
            if (ar_fire) begin
               exp_rresp = 2'b00;
               exp_rdata = 32'h0;
               if (bus.araddr == RSP_ADDR) begin
                  if (rsz > 0) begin
                     exp_rdata = rsp_q[0];
                     rsp_pop = 1;
                  end else begin
                     exp_rdata = 32'hE000_0000;
                  end
               end else if (bus.araddr == STAT_ADDR) begin
                  exp_rdata = {drop_m, 8'(rsz), 8'(csz), 6'b0, rsz == 0, csz == CMD_DEPTH};
               end else if (!is_cmd(bus.araddr)) begin
                  exp_rresp = 2'b11;
               end
            end
            if (w_fire) begin
               if (is_cmd(w_addr)) begin
                  if (bus.wstrb != 4'hF || csz == CMD_DEPTH) begin
                     exp_bresp = 2'b10;
                     if (drop_m != 8'hFF) drop_m = drop_m + 8'h1;
                  end else begin
                     cmd_push  = 1;
                     new_cmd   = {CH_W'((w_addr - CMD_BASE) / 4), op_map(bus.wdata[31:29]),
                                  bus.wdata[28], bus.wdata[27:0]};
                     exp_bresp = 2'b00;
                  end
               end else if (w_addr == STAT_ADDR) begin
                  drop_m    = 8'h0;
                  exp_bresp = 2'b00;
               end else begin
                  exp_bresp = 2'b11;
               end
            end
            if (cmd_pop)  void'(cmd_q.pop_front());
            if (cmd_push) cmd_q.push_back(new_cmd);
            if (rsp_pop)  void'(rsp_q.pop_front());
            if (rsp_push) rsp_q.push_back({bus.rsp_op, bus.rsp_mo, bus.rsp_id});
            if (r_fire)  r_pend = 0;
            if (ar_fire) r_pend = 1;
            if (aw_fire) begin aw_got = 1; w_addr = bus.awaddr; end
            if (w_fire)  begin aw_got = 0; b_pend = 1; end
            if (b_fire)  b_pend = 0;
         end
      end
   endtask

   task automatic cmd_ready_drv();
      forever begin
         @(posedge clk);
         #1;
         bus.cmd_ready = (cr_mode == 1) ? 1'b1 : (cr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   endtask

   task automatic rsp_drv();
      bit dir_active = 0;
      forever begin
         bit fired;
         @(negedge clk);
         fired = bus.rsp_valid && bus.rsp_ready;
         @(posedge clk);
         #1;
         if (fired && dir_active && dir_q.size() != 0) void'(dir_q.pop_front());
         if (dir_q.size() != 0) begin
            dir_active = 1;
            bus.rsp_valid = 1'b1;
            {bus.rsp_op, bus.rsp_mo, bus.rsp_id} = dir_q[0];
         end else begin
            dir_active = 0;
            bus.rsp_valid = (rv_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            {bus.rsp_op, bus.rsp_mo, bus.rsp_id} = $urandom;
         end
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit hold_b, output logic [1:0] resp);
      int n;
      resp = 2'bxx;
      @(posedge clk);
      #1;
      bus.awvalid = 1'b1; bus.awaddr = a;
      bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.awready && n < LIM);
      if (!bus.awready) tmo("aw");
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.wready && n < LIM);
      if (!bus.wready) tmo("w");
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      bus.bready = hold_b ? 1'b0 : 1'($urandom_range(0, 1));
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.bvalid && (hold_b || bus.bready)) begin resp = bus.bresp; break; end
         n++;
         if (n > LIM) begin tmo("b"); break; end
         @(posedge clk);
         #1;
         bus.bready = hold_b ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (!hold_b) begin
         @(posedge clk);
         #1;
         bus.bready = 1'b0;
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      d = 32'hx; resp = 2'bxx;
      @(posedge clk);
      #1;
      bus.arvalid = 1'b1; bus.araddr = a;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.arready && n < LIM);
      if (!bus.arready) tmo("ar");
      @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
      bus.rready  = 1'($urandom_range(0, 1));
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.rvalid && bus.rready) begin d = bus.rdata; resp = bus.rresp; break; end
         n++;
         if (n > LIM) begin tmo("r"); break; end
         @(posedge clk);
         #1;
         bus.rready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      bus.rready = 1'b0;
   endtask

   task automatic wait_dir_drain();
      int n = 0;
      while (dir_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
      chk("rsp_inject_drain", 64'(dir_q.size()), 64'd0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      logic [1:0]  br, rr;
      logic [31:0] rdv;
      logic [31:0] addrs [8];
      int          p0;

      bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
      bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
      bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_op = 0; bus.rsp_mo = 0; bus.rsp_id = 0;
      addrs = '{CMD_BASE, CMD_BASE + 4, CMD_BASE + 8, CMD_BASE + 12, CMD_BASE + 16,
                STAT_ADDR, RSP_ADDR, 32'h700};

      fork
         monitor();
         cmd_ready_drv();
         rsp_drv();
      join_none

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_awready", bus.awready, 1'b1);
      chk("reset_cmd_valid", bus.cmd_valid, 1'b0);
      chk("reset_rsp_ready", bus.rsp_ready, 1'b1);

      // 1) single command on channel 2
      cr_mode = 1;
      repeat (2) @(posedge clk);
      p0 = pops;
      wr(CMD_BASE + 8, 32'h2000_0005, 4'hF, 0, br);
      chk("t1_bresp", br, 2'b00);
      repeat (3) @(posedge clk);
      chk("t1_pops", 64'(pops - p0), 64'd1);
      chk("t1_cmd", last_cmd, {2'd2, 3'd1, 1'b0, 28'd5});

      // 2) overfill the command FIFO
      cr_mode = 0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < CMD_DEPTH + 2; i++) begin
         wr(CMD_BASE + 32'(4 * (i % 4)), 32'(i), 4'hF, 0, br);
         chk("t2_bresp", br, (i < CMD_DEPTH) ? 2'b00 : 2'b10);
      end
      rd(STAT_ADDR, rdv, rr);
      chk("t2_stat_full", rdv, 32'h0200_1003);
      wr(STAT_ADDR, 32'h0, 4'hF, 0, br);
      chk("t2_stat_wr", br, 2'b00);
      rd(STAT_ADDR, rdv, rr);
      chk("t2_stat_clr", rdv, 32'h0000_1003);
      cr_mode = 1;
      repeat (25) @(posedge clk);

      // 3) MSC op mapping and partial strobe rejection
      cr_mode = 0;
      repeat (2) @(posedge clk);
      wr(CMD_BASE, 32'hF000_0001, 4'hF, 0, br);
      chk("t3_bresp", br, 2'b00);
      @(negedge clk);
      chk("t3_cmd_op", {bus.cmd_valid, bus.cmd_op, bus.cmd_mo, bus.cmd_id}, {1'b1, 3'd4, 1'b1, 28'd1});
      wr(CMD_BASE, 32'hF000_0001, 4'h3, 0, br);
      chk("t3_strb_bresp", br, 2'b10);
      rd(STAT_ADDR, rdv, rr);
      chk("t3_stat", rdv, 32'h0100_0102);
      cr_mode = 1;

      // drop counter saturation
      for (int i = 0; i < 260; i++) wr(CMD_BASE + 4, 32'h0, 4'h0, 0, br);
      rd(STAT_ADDR, rdv, rr);
      chk("sat_drop", rdv[31:24], 8'hFF);
      wr(STAT_ADDR, 32'h0, 4'hF, 0, br);
      rd(STAT_ADDR, rdv, rr);
      chk("sat_clear", rdv, 32'h0000_0002);

      // 4) response pops then empty marker
      for (int i = 7; i <= 9; i++) dir_q.push_back({3'd1, 1'b1, 28'(i)});
      wait_dir_drain();
      for (int i = 0; i < 3; i++) begin
         rd(RSP_ADDR, rdv, rr);
         chk("t4_rsp", rdv, 32'h3000_0007 + 32'(i));
      end
      rd(RSP_ADDR, rdv, rr);
      chk("t4_empty", rdv, 32'hE000_0000);
      chk("t4_empty_resp", rr, 2'b00);

      // 5) response FIFO full, decode errors
      for (int i = 0; i < RSP_DEPTH; i++) dir_q.push_back({3'd1, 1'b1, 28'(100 + i)});
      wait_dir_drain();
      @(negedge clk);
      chk("t5_rsp_full", bus.rsp_ready, 1'b0);
      rd(RSP_ADDR, rdv, rr);
      chk("t5_first", rdv, 32'h3000_0064);
      @(negedge clk);
      chk("t5_rsp_ready", bus.rsp_ready, 1'b1);
      rd(32'h700, rdv, rr);
      chk("t5_rd_decerr", {rr, rdv}, {2'b11, 32'h0});
      wr(32'h700, 32'h1234_5678, 4'hF, 0, br);
      chk("t5_wr_decerr", br, 2'b11);
      for (int i = 1; i < RSP_DEPTH; i++) begin
         rd(RSP_ADDR, rdv, rr);
         chk("t5_drain", rdv, 32'h3000_0064 + 32'(i));
      end

      // 6) reset in the middle of a write response
      cr_mode = 0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 5; i++) wr(CMD_BASE + 4, 32'(i), 4'hF, 0, br);
      wr(CMD_BASE + 12, 32'h6, 4'hF, 1, br);
      chk("t6_bvalid_before", bus.bvalid, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_after_rst", {bus.bvalid, bus.cmd_valid, bus.awready, bus.rvalid}, 4'b0010);
      rd(STAT_ADDR, rdv, rr);
      chk("t6_stat", rdv, 32'h0000_0002);

      // randomized traffic
      cr_mode = 2;
      rv_mode = 2;
      for (int it = 0; it < 300; it++) begin
         int          kind = $urandom_range(0, 2);
         logic [31:0] wa   = addrs[$urandom_range(0, 7)];
         logic [31:0] ra   = ($urandom_range(0, 1) == 1) ? RSP_ADDR : addrs[$urandom_range(0, 7)];
         logic [31:0] wd   = $urandom;
         logic [3:0]  ws   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
         if (kind == 0) wr(wa, wd, ws, 0, br);
         else if (kind == 1) rd(ra, rdv, rr);
         else fork
            wr(wa, wd, ws, 0, br);
            rd(ra, rdv, rr);
         join
      end
      rv_mode = 0;
      cr_mode = 1;
      repeat (30) @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
